// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared raster constants for the HDMI overlay path.
//   COORD_W        : coordinate width shared with the overlay enable control
//   MAX_TOTAL      : largest axis total representable in COORD_W bits
//   P1080_* / P720_* : CEA 1080p60 and 720p60 timing presets
//   axis_total()   : ACTIVE+FP+SYNC+BP for one axis
// -----------------------------------------------------------------------------
package video_timing_pkg;

    localparam int unsigned COORD_W   = 12;
    localparam int unsigned MAX_TOTAL = 1 << COORD_W;

    // 1920x1080 @ 60 Hz, 148.5 MHz pixel clock
    localparam int unsigned P1080_H_ACTIVE = 1920;
    localparam int unsigned P1080_H_FP     = 88;
    localparam int unsigned P1080_H_SYNC   = 44;
    localparam int unsigned P1080_H_BP     = 148;
    localparam int unsigned P1080_V_ACTIVE = 1080;
    localparam int unsigned P1080_V_FP     = 4;
    localparam int unsigned P1080_V_SYNC   = 5;
    localparam int unsigned P1080_V_BP     = 36;
    localparam bit          P1080_H_POL    = 1'b1;
    localparam bit          P1080_V_POL    = 1'b1;

    // 1280x720 @ 60 Hz, 74.25 MHz pixel clock
    localparam int unsigned P720_H_ACTIVE  = 1280;
    localparam int unsigned P720_H_FP      = 110;
    localparam int unsigned P720_H_SYNC    = 40;
    localparam int unsigned P720_H_BP      = 220;
    localparam int unsigned P720_V_ACTIVE  = 720;
    localparam int unsigned P720_V_FP      = 5;
    localparam int unsigned P720_V_SYNC    = 5;
    localparam int unsigned P720_V_BP      = 20;
    localparam bit          P720_H_POL     = 1'b1;
    localparam bit          P720_V_POL     = 1'b1;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// -----------------------------------------------------------------------------
// video_axis_counter
// One raster axis: position counter with wrap, active and sync decodes.
// Layout along the axis: active, front porch, sync, back porch.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_run          : generator will be running next cycle; low clears the axis
//   i_step         : advance the position by one this cycle
//   o_count        : registered position, 0..TOTAL-1
//   o_wrap         : this cycle steps from TOTAL-1 back to 0 (combinational)
//   o_active       : next position lies in the active region (combinational)
//   o_sync         : registered sync, POL when asserted, aligned with o_count
// -----------------------------------------------------------------------------
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = P1080_H_ACTIVE,
    parameter int unsigned FP     = P1080_H_FP,
    parameter int unsigned SYNC   = P1080_H_SYNC,
    parameter int unsigned BP     = P1080_H_BP,
    parameter bit          POL    = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_step,
    output logic [COORD_W-1:0] o_count,
    output logic               o_wrap,
    output logic               o_active,
    output logic               o_sync
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    if (TOTAL > MAX_TOTAL) begin : g_total_too_large
        $error("video_axis_counter: axis total %0d exceeds %0d", TOTAL, MAX_TOTAL);
    end

    localparam logic [COORD_W-1:0] L_LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] L_ACTIVE     = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] L_SYNC_FIRST = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] L_SYNC_LAST  = COORD_W'(ACTIVE + FP + SYNC - 1);

    logic [COORD_W-1:0] r_count;
    logic               r_sync;
    logic [COORD_W-1:0] w_next;
    logic               w_last;
    logic               w_in_sync;

    // Decodes are taken from the next position and registered alongside it,
    // so sync lines up with the count it describes.
    always_comb begin
        w_last = (r_count == L_LAST);
        w_next = r_count;
        if (!i_run) begin
            w_next = '0;
        end else if (i_step) begin
            w_next = w_last ? '0 : r_count + 1'b1;
        end
        o_wrap    = i_step && w_last;
        o_active  = (w_next < L_ACTIVE);
        w_in_sync = (w_next >= L_SYNC_FIRST) && (w_next <= L_SYNC_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_sync  <= ~POL;
        end else begin
            r_count <= w_next;
            r_sync  <= (i_run && w_in_sync) ? POL : ~POL;
        end
    end

    assign o_count = r_count;
    assign o_sync  = r_sync;

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// -----------------------------------------------------------------------------
// hdmi_video_timing_gen
// Free-running raster timing generator for the HDMI overlay path.
//   pixel_clock   : pixel clock, all state on the rising edge
//   reset_n       : asynchronous active-low reset
//   timing_enable : run request; low holds the generator idle at (0,0)
//   x_counter     : horizontal position, 0..H_TOTAL-1
//   y_counter     : vertical position, 0..V_TOTAL-1
//   hsync, vsync  : syncs, asserted level H_POL / V_POL
//   de            : data enable, high in the active region
//   frame_start   : one-cycle pulse at (0,0)
//   line_start    : one-cycle pulse at x_counter=0
// All outputs are registered and describe the pixel shown on x/y that cycle.
// -----------------------------------------------------------------------------
module hdmi_video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = P1080_H_ACTIVE,
    parameter int unsigned H_FP     = P1080_H_FP,
    parameter int unsigned H_SYNC   = P1080_H_SYNC,
    parameter int unsigned H_BP     = P1080_H_BP,
    parameter int unsigned V_ACTIVE = P1080_V_ACTIVE,
    parameter int unsigned V_FP     = P1080_V_FP,
    parameter int unsigned V_SYNC   = P1080_V_SYNC,
    parameter int unsigned V_BP     = P1080_V_BP,
    parameter bit          H_POL    = P1080_H_POL,
    parameter bit          V_POL    = P1080_V_POL
) (
    input  logic               pixel_clock,
    input  logic               reset_n,
    input  logic               timing_enable,
    output logic [COORD_W-1:0] x_counter,
    output logic [COORD_W-1:0] y_counter,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic               line_start
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] r_state;
    logic       r_de;
    logic       r_frame_start;
    logic       r_line_start;

    logic       w_h_step;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_h_active;
    logic       w_v_active;

    // Counting only happens while already in RUN; the IDLE->RUN edge lands
    // on (0,0) because the counters are held at zero in IDLE.
    assign w_h_step = (r_state == ST_RUN);

    video_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .i_clk    (pixel_clock),
        .i_rst_n  (reset_n),
        .i_run    (timing_enable),
        .i_step   (w_h_step),
        .o_count  (x_counter),
        .o_wrap   (w_h_wrap),
        .o_active (w_h_active),
        .o_sync   (hsync)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .i_clk    (pixel_clock),
        .i_rst_n  (reset_n),
        .i_run    (timing_enable),
        .i_step   (w_h_wrap),
        .o_count  (y_counter),
        .o_wrap   (w_v_wrap),
        .o_active (w_v_active),
        .o_sync   (vsync)
    );

    // Next state equals the sampled enable in both states; dropping the
    // enable aborts the frame and the next enable restarts at (0,0).
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_state       <= timing_enable ? ST_RUN : ST_IDLE;
            r_de          <= timing_enable && w_h_active && w_v_active;
            r_line_start  <= timing_enable && ((r_state == ST_IDLE) || w_h_wrap);
            r_frame_start <= timing_enable && ((r_state == ST_IDLE) || w_v_wrap);
        end
    end

    assign de          = r_de;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
module tb_hdmi_video_timing_gen;
    import video_timing_pkg::*;

    logic clk;
    logic reset_n;
    logic en;

    // 1080p default instance
    logic [11:0] d_x, d_y;
    logic        d_hs, d_vs, d_de, d_fs, d_ls;
    // 720p override instance
    logic [11:0] m_x, m_y;
    logic        m_hs, m_vs, m_de, m_fs, m_ls;
    // tiny raster (15x11) for frame-level behaviour, active-low hsync
    logic [11:0] s_x, s_y;
    logic        s_hs, s_vs, s_de, s_fs, s_ls;

    int total = 0;
    int bad   = 0;

    hdmi_video_timing_gen u_dut (
        .pixel_clock   (clk),
        .reset_n       (reset_n),
        .timing_enable (en),
        .x_counter     (d_x),
        .y_counter     (d_y),
        .hsync         (d_hs),
        .vsync         (d_vs),
        .de            (d_de),
        .frame_start   (d_fs),
        .line_start    (d_ls)
    );

    hdmi_video_timing_gen #(
        .H_ACTIVE (P720_H_ACTIVE), .H_FP (P720_H_FP), .H_SYNC (P720_H_SYNC), .H_BP (P720_H_BP),
        .V_ACTIVE (P720_V_ACTIVE), .V_FP (P720_V_FP), .V_SYNC (P720_V_SYNC), .V_BP (P720_V_BP),
        .H_POL    (P720_H_POL),    .V_POL (P720_V_POL)
    ) u_720 (
        .pixel_clock   (clk),
        .reset_n       (reset_n),
        .timing_enable (en),
        .x_counter     (m_x),
        .y_counter     (m_y),
        .hsync         (m_hs),
        .vsync         (m_vs),
        .de            (m_de),
        .frame_start   (m_fs),
        .line_start    (m_ls)
    );

    hdmi_video_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .H_POL    (1'b0), .V_POL (1'b1)
    ) u_small (
        .pixel_clock   (clk),
        .reset_n       (reset_n),
        .timing_enable (en),
        .x_counter     (s_x),
        .y_counter     (s_y),
        .hsync         (s_hs),
        .vsync         (s_vs),
        .de            (s_de),
        .frame_start   (s_fs),
        .line_start    (s_ls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned adv;
        logic [11:0] x;
        logic [11:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        ls;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [11:0] x, input logic [11:0] y,
                           input logic de, input logic hs, input logic vs,
                           input logic fs, input logic ls);
        check({tag, ".x"},  32'(d_x),  32'(x));
        check({tag, ".y"},  32'(d_y),  32'(y));
        check({tag, ".de"}, 32'(d_de), 32'(de));
        check({tag, ".hs"}, 32'(d_hs), 32'(hs));
        check({tag, ".vs"}, 32'(d_vs), 32'(vs));
        check({tag, ".fs"}, 32'(d_fs), 32'(fs));
        check({tag, ".ls"}, 32'(d_ls), 32'(ls));
    endtask

    initial begin
        int unsigned ex, ey;
        logic        e_de, e_hs, e_vs, e_fs, e_ls;
        int d_ls2, m_ls2, s_fs2;
        int d_hs_cnt, d_hs_first, m_hs_cnt, m_de_cnt;
        int s_de_cnt, s_vs_cnt, s_hs_low, s_fs_cnt;

        //            adv   x     y  de hs vs fs ls
        vecs[0] = '{1,    12'd0,    12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1,    12'd1,    12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1918, 12'd1919, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1,    12'd1920, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{87,   12'd2007, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1,    12'd2008, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{43,   12'd2051, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1,    12'd2052, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{147,  12'd2199, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1,    12'd0,    12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0;
        en      = 1'b0;
        repeat (3) tick();
        check_d("reset", 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.small_hs", 32'(s_hs), 32'd1);

        reset_n = 1'b1;
        tick();
        tick();
        check_d("idle", 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // First line of 1080p from enable
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (vecs[i].adv) tick();
            check_d($sformatf("line_vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].de,
                    vecs[i].hs, vecs[i].vs, vecs[i].fs, vecs[i].ls);
        end

        // Drop enable mid-line, re-raise three cycles later
        repeat (1000) tick();
        check_d("pre_abort", 12'd1000, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        check_d("abort", 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_d("abort_hold", 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        check_d("restart", 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset mid-line, checked before the next clock edge
        repeat (700) tick();
        check_d("pre_reset", 12'd700, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_d("async_reset", 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("async_reset.small_hs", 32'(s_hs), 32'd1);
        en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_d("post_reset_idle", 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        check_d("post_reset_run", 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("m720.start_x", 32'(m_x), 32'd0);
        check("m720.start_y", 32'(m_y), 32'd0);
        check("m720.start_fs", 32'(m_fs), 32'd1);
        check("m720.start_vs", 32'(m_vs), 32'd0);

        // Periods and counts; k=0 is the (0,0) sample above
        d_ls2 = -1; m_ls2 = -1; s_fs2 = -1;
        d_hs_cnt = 0; d_hs_first = -1; m_hs_cnt = 0; m_de_cnt = 0;
        s_de_cnt = 0; s_vs_cnt = 0; s_hs_low = 0; s_fs_cnt = 0;
        for (int k = 0; k < 4500; k++) begin
            if (k > 0) tick();
            if (k > 0 && d_ls && d_ls2 < 0) d_ls2 = k;
            if (k > 0 && m_ls && m_ls2 < 0) m_ls2 = k;
            if (k < 2200 && d_hs) begin
                d_hs_cnt++;
                if (d_hs_first < 0) d_hs_first = k;
            end
            if (k < 1650) begin
                if (m_hs) m_hs_cnt++;
                if (m_de) m_de_cnt++;
            end
            if (k < 330) begin
                ex   = k % 15;
                ey   = (k / 15) % 11;
                e_de = (ex < 8) && (ey < 6);
                e_hs = !((ex >= 10) && (ex <= 12));
                e_vs = (ey == 7) || (ey == 8);
                e_fs = (ex == 0) && (ey == 0);
                e_ls = (ex == 0);
                check($sformatf("small_raster_k%0d", k),
                      32'({s_x, s_y, s_de, s_hs, s_vs, s_fs, s_ls}),
                      32'({ex[11:0], ey[11:0], e_de, e_hs, e_vs, e_fs, e_ls}));
                if (s_de) s_de_cnt++;
                if (s_vs) s_vs_cnt++;
                if (!s_hs) s_hs_low++;
                if (s_fs) s_fs_cnt++;
                if (k > 0 && s_fs && s_fs2 < 0) s_fs2 = k;
            end
        end
        check("p1080.line_period", 32'(d_ls2), 32'd2200);
        check("p1080.hsync_cycles", 32'(d_hs_cnt), 32'd44);
        check("p1080.hsync_first_x", 32'(d_hs_first), 32'd2008);
        check("p720.line_period", 32'(m_ls2), 32'd1650);
        check("p720.hsync_cycles", 32'(m_hs_cnt), 32'd40);
        check("p720.de_cycles_line0", 32'(m_de_cnt), 32'd1280);
        check("small.frame_period", 32'(s_fs2), 32'd165);
        check("small.frame_pulses", 32'(s_fs_cnt), 32'd2);
        check("small.de_cycles", 32'(s_de_cnt), 32'd96);
        check("small.vsync_cycles", 32'(s_vs_cnt), 32'd60);
        check("small.hsync_low_cycles", 32'(s_hs_low), 32'd66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
